// File: rtl/control_unit_mc.sv
// Multicycle control unit: DECODE/EXEC/MEM/WB sequencing with memory timeout and illegal-opcode trap.
// Optional CU_FASTBRANCH_EN resolves BEQ/BNE in DECODE (2-cycle branches).
module control_unit_mc #(
  parameter int OPW      = 5,
  parameter int ALUW     = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            INSTR_VALID,
  output logic            INSTR_ACK,
  input  logic [OPW-1:0]  OPCODE,
  input  logic [ALUW-1:0] ALUOP,
  input  logic            ZERO,
  input  logic            MEM_READY,
  input  logic            CLR_TRAP,
  output logic            WE,
  output logic            DataInputS,
  output logic            DataInputON,
  output logic            OpbSelect,
  output logic            RWrite,
  output logic            Branch,
  output logic            SelectMem,
  output logic            R2S,
  output logic [ALUW-1:0] ALUSignal,
  output logic            PC_EN,
  output logic            BUSY,
  output logic            ILLEGAL,
  output logic            TIMEOUT
);
  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_LDR  = OPW'(1);
  localparam logic [OPW-1:0] OP_STR  = OPW'(2);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(3);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(5);
  localparam logic [ALUW-1:0] ALU_SUB = ALUW'(1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t          state;
  logic [OPW-1:0]  ir_op;
  logic [ALUW-1:0] ir_aluop;
  logic [4:0]      dec_ctl;   // {DataInputS,DataInputON,OpbSelect,SelectMem,R2S}
  logic [ALUW-1:0] dec_alu;
  logic [CW-1:0]   cnt;
  logic            illegal_q, timeout_q;

  logic            d_legal;
  logic [4:0]      d_ctl;
  logic [ALUW-1:0] d_alu;
  logic            is_ld, is_st, is_br, taken, act;

  always_comb begin
    d_legal = 1'b1;
    d_ctl   = '0;
    d_alu   = '0;
    case (ir_op)
      OP_R:    begin d_ctl = 5'b11000; d_alu = ir_aluop; end
      OP_LDR:  d_ctl = 5'b01110;
      OP_STR:  d_ctl = 5'b10100;
      OP_BEQ:  begin d_ctl = 5'b11001; d_alu = ALU_SUB; end
      OP_ADDI: d_ctl = 5'b11100;
      OP_BNE:  begin d_ctl = 5'b11001; d_alu = ALU_SUB; end
      default: d_legal = 1'b0;
    endcase
  end

  assign is_ld = (ir_op == OP_LDR);
  assign is_st = (ir_op == OP_STR);
  assign is_br = (ir_op == OP_BEQ) || (ir_op == OP_BNE);
  assign taken = ((ir_op == OP_BEQ) && ZERO) || ((ir_op == OP_BNE) && !ZERO);
  assign act   = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  // State decodes from async-reset flops, so RST clears outputs immediately;
  // ACK is also masked so an offer held during reset is not seen as accepted.
  assign INSTR_ACK = (state == S_IDLE) && INSTR_VALID && !RST;
  assign BUSY      = (state != S_IDLE);
  assign WE        = (state == S_MEM) && is_st;
  assign RWrite    = (state == S_WB);
  assign ILLEGAL   = illegal_q;
  assign TIMEOUT   = timeout_q;
  assign {DataInputS, DataInputON, OpbSelect, SelectMem, R2S} = act ? dec_ctl : 5'b0;

  always_comb begin
    ALUSignal = act ? dec_alu : '0;
`ifdef CU_FASTBRANCH_EN
    if (state == S_DECODE && is_br) ALUSignal = ALU_SUB;
    Branch = (state == S_DECODE) && taken;
    PC_EN  = ((state == S_DECODE) && is_br) ||
             ((state == S_MEM) && is_st && MEM_READY) || (state == S_WB);
`else
    Branch = (state == S_EXEC) && taken;
    PC_EN  = ((state == S_EXEC) && is_br) ||
             ((state == S_MEM) && is_st && MEM_READY) || (state == S_WB);
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      ir_op     <= '0;
      ir_aluop  <= '0;
      dec_ctl   <= '0;
      dec_alu   <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (INSTR_VALID) begin
          ir_op    <= OPCODE;
          ir_aluop <= ALUOP;
          state    <= S_DECODE;
        end
        S_DECODE: if (!d_legal) begin
          illegal_q <= 1'b1;
          state     <= S_TRAP;
        end else begin
          dec_ctl <= d_ctl;
          dec_alu <= d_alu;
`ifdef CU_FASTBRANCH_EN
          state   <= is_br ? S_IDLE : S_EXEC;
`else
          state   <= S_EXEC;
`endif
        end
        S_EXEC: if (is_ld || is_st) begin
          cnt   <= '0;
          state <= S_MEM;
        end else begin
          state <= is_br ? S_IDLE : S_WB;
        end
        // Ready in the last allowed cycle takes priority over the timeout.
        S_MEM: if (MEM_READY) begin
          state <= is_ld ? S_WB : S_IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout_q <= 1'b1;
          state     <= S_TRAP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        S_WB: state <= S_IDLE;
        S_TRAP: if (CLR_TRAP) begin
          illegal_q <= 1'b0;
          timeout_q <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
